// File: rtl/fb_scanout_engine_pkg.sv
// Shared definitions for the framebuffer scanout engine.
//   FB_LINE_BITS        : width of one memory line (128 bytes)
//   fb_line_t           : one memory line of framebuffer data
//   scan_fetch_state_e  : encoding of the line-fetch FSM state
package fb_scanout_engine_pkg;

  localparam int FB_LINE_BITS = 1024;

  typedef logic [FB_LINE_BITS-1:0] fb_line_t;

  typedef logic [1:0] scan_fetch_state_e;

  localparam scan_fetch_state_e F_IDLE = 2'd0;
  localparam scan_fetch_state_e F_REQ  = 2'd1;
  localparam scan_fetch_state_e F_WAIT = 2'd2;

endpackage

// File: rtl/fb_scanout_engine_line_buffer.sv
// Two-entry ping-pong line store between the memory fetch and the pixel stream.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   clr         : drop both entries and rewind both pointers (new frame)
//   push        : write push_data into the entry at wr_ptr, mark it valid
//   pop         : release the entry at rd_ptr
//   rd_data     : contents of the entry at rd_ptr
//   full/empty  : no free entry to write / nothing valid to read
module fb_scanout_engine_line_buffer
  import fb_scanout_engine_pkg::*;
#(
  parameter int LINE_BITS = FB_LINE_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 push,
  input  logic [LINE_BITS-1:0] push_data,
  input  logic                 pop,
  output logic [LINE_BITS-1:0] rd_data,
  output logic                 full,
  output logic                 empty
);

  logic [LINE_BITS-1:0] mem [2];
  logic [1:0]           vld;
  logic                 wr_ptr;
  logic                 rd_ptr;

  // Pointers only advance onto entries whose valid bit allows it, so a
  // same-cycle push and pop always touch different entries.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      vld    <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) begin
        vld[wr_ptr] <= 1'b1;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        vld[rd_ptr] <= 1'b0;
        rd_ptr      <= ~rd_ptr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  assign rd_data = mem[rd_ptr];
  assign full    = vld[wr_ptr];
  assign empty   = !vld[rd_ptr];

endmodule

// File: rtl/fb_scanout_engine.sv
// Reads a 1bpp framebuffer from memory one line at a time and streams its
// pixels in raster order over a valid/ready interface.
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   start, fb_base    : frame request (taken only when idle) and byte base
//   busy, done        : frame in progress / one-cycle end-of-frame pulse
//   mem_req_*         : line read request (valid/ready, 128 B aligned addr)
//   mem_rsp_*         : line data return
//   pix_valid/ready   : pixel beat handshake
//   pix_data/x/y      : pixel value and its coordinates
//   pix_sof/eol/eof   : first pixel of frame / last of row / last of frame
//
// Fetch FSM:
//   state  | meaning
//   F_IDLE | no request outstanding; waits for a free buffer and lines left
//   F_REQ  | mem_req_valid held until memory accepts
//   F_WAIT | request accepted, waiting for the line data
module fb_scanout_engine
  import fb_scanout_engine_pkg::*;
#(
  parameter int FB_WIDTH  = 64,
  parameter int FB_HEIGHT = 64,
  parameter int LINE_BITS = FB_LINE_BITS,
  parameter int ADDR_W    = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [ADDR_W-1:0]             fb_base,
  output logic                          busy,
  output logic                          done,
  output logic                          mem_req_valid,
  input  logic                          mem_req_ready,
  output logic [ADDR_W-1:0]             mem_req_addr,
  input  logic                          mem_rsp_valid,
  input  logic [LINE_BITS-1:0]          mem_rsp_data,
  output logic                          pix_valid,
  input  logic                          pix_ready,
  output logic                          pix_data,
  output logic [$clog2(FB_WIDTH)-1:0]   pix_x,
  output logic [$clog2(FB_HEIGHT)-1:0]  pix_y,
  output logic                          pix_sof,
  output logic                          pix_eol,
  output logic                          pix_eof
);

  localparam int NUM_PIX    = FB_WIDTH * FB_HEIGHT;
  localparam int NUM_LINES  = NUM_PIX / LINE_BITS;
  localparam int X_W        = $clog2(FB_WIDTH);
  localparam int Y_W        = $clog2(FB_HEIGHT);
  localparam int P_W        = X_W + Y_W;
  localparam int LB_W       = $clog2(LINE_BITS);
  localparam int LI_W       = $clog2(NUM_LINES) + 1;
  localparam int LINE_BYTES = LINE_BITS / 8;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(LINE_BYTES - 1);

  scan_fetch_state_e   fstate;
  logic [LI_W-1:0]     lines_issued;
  logic [ADDR_W-1:0]   base_q;
  logic [P_W-1:0]      p;

  logic                start_acc;
  logic                hs;
  logic                line_last;
  logic                frame_last;
  logic                buf_push;
  logic                buf_full;
  logic                buf_empty;
  logic [LINE_BITS-1:0] rd_line;

  assign start_acc  = start && !busy;
  assign hs         = pix_valid && pix_ready;
  assign line_last  = hs && (p[LB_W-1:0] == LB_W'(LINE_BITS - 1));
  assign frame_last = hs && (p == P_W'(NUM_PIX - 1));
  assign buf_push   = (fstate == F_WAIT) && mem_rsp_valid;

  fb_scanout_engine_line_buffer #(
    .LINE_BITS (LINE_BITS)
  ) u_line_buffer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (start_acc),
    .push      (buf_push),
    .push_data (mem_rsp_data),
    .pop       (line_last),
    .rd_data   (rd_line),
    .full      (buf_full),
    .empty     (buf_empty)
  );

  // An accepted start goes straight to F_REQ so the first request appears
  // the cycle after start. A buffer being popped this cycle counts as free.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fstate       <= F_IDLE;
      lines_issued <= '0;
    end else if (start_acc) begin
      fstate       <= F_REQ;
      lines_issued <= '0;
    end else begin
      case (fstate)
        F_IDLE: begin
          if (busy && (!buf_full || line_last) &&
              (lines_issued < LI_W'(NUM_LINES))) begin
            fstate <= F_REQ;
          end
        end
        F_REQ: begin
          if (mem_req_ready) begin
            fstate       <= F_WAIT;
            lines_issued <= lines_issued + 1'b1;
          end
        end
        F_WAIT: begin
          if (mem_rsp_valid) begin
            fstate <= F_IDLE;
          end
        end
        default: fstate <= F_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      base_q <= '0;
      p      <= '0;
    end else begin
      done <= frame_last;
      if (start_acc) begin
        busy   <= 1'b1;
        base_q <= fb_base & ALIGN_MASK;
        p      <= '0;
      end else if (frame_last) begin
        busy <= 1'b0;
        p    <= '0;
      end else if (hs) begin
        p <= p + 1'b1;
      end
    end
  end

  assign mem_req_valid = (fstate == F_REQ);
  assign mem_req_addr  = base_q + (ADDR_W'(lines_issued) << $clog2(LINE_BYTES));

  // Everything below is a function of p and the read buffer, both of which
  // only change on a handshake, so stalls keep the beat stable.
  assign pix_valid = busy && !buf_empty;
  assign pix_data  = pix_valid && rd_line[p[LB_W-1:0]];
  assign pix_x     = p[X_W-1:0];
  assign pix_y     = p[P_W-1:X_W];
  assign pix_sof   = pix_valid && (p == '0);
  assign pix_eol   = pix_valid && (pix_x == X_W'(FB_WIDTH - 1));
  assign pix_eof   = pix_valid && (p == P_W'(NUM_PIX - 1));

endmodule

// File: tb/tb_fb_scanout_engine.sv
module tb_fb_scanout_engine;

  localparam int W      = 64;
  localparam int H      = 64;
  localparam int LB     = 1024;
  localparam int NPIX   = W * H;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [31:0]     fb_base;
  logic            busy, done;
  logic            mem_req_valid, mem_req_ready;
  logic [31:0]     mem_req_addr;
  logic            mem_rsp_valid;
  logic [LB-1:0]   mem_rsp_data;
  logic            pix_valid, pix_ready, pix_data;
  logic [5:0]      pix_x, pix_y;
  logic            pix_sof, pix_eol, pix_eof;

  always #5 clk = ~clk;

  fb_scanout_engine dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .fb_base       (fb_base),
    .busy          (busy),
    .done          (done),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .pix_valid     (pix_valid),
    .pix_ready     (pix_ready),
    .pix_data      (pix_data),
    .pix_x         (pix_x),
    .pix_y         (pix_y),
    .pix_sof       (pix_sof),
    .pix_eol       (pix_eol),
    .pix_eof       (pix_eof)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Golden framebuffer image and scoreboard queues
  logic [NPIX-1:0] img;
  logic [31:0]     cur_base;
  logic [15:0]     exp_beats[$];
  logic [31:0]     exp_addrs[$];

  function automatic logic [15:0] golden(input int p);
    logic [5:0] x, y;
    x = 6'(p % W);
    y = 6'(p / W);
    return {img[p], x, y, (p == 0), (x == 6'd63), (p == NPIX - 1)};
  endfunction

  // Memory model: ready always high, one response per request after `latency`
  int          latency   = 0;
  int          ready_pct = 100;
  logic        rsp_pending = 1'b0;
  int          rsp_wait;
  logic [31:0] rsp_addr;
  logic        pv_check = 1'b0;
  int          delivered = 0;

  initial begin
    int line_idx;
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    pix_ready     = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (pv_check) begin
        check("pix_valid_after_first_rsp", pix_valid, 1);
        pv_check = 1'b0;
      end
      mem_rsp_valid = 1'b0;
      if (rsp_pending) begin
        if (rsp_wait == 0) begin
          line_idx      = int'((rsp_addr - cur_base) >> 7) & 3;
          mem_rsp_valid = 1'b1;
          mem_rsp_data  = img[line_idx*LB +: LB];
          rsp_pending   = 1'b0;
          if (busy) begin
            delivered++;
            if (rsp_addr == cur_base) pv_check = 1'b1;
          end
        end else begin
          rsp_wait--;
        end
      end
      if (rst_n && mem_req_valid && mem_req_ready) begin
        check("one_outstanding", rsp_pending, 0);
        if (exp_addrs.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL req_unexpected: got addr 0x%0h, expected no request", mem_req_addr);
        end else begin
          check("req_addr", mem_req_addr, exp_addrs.pop_front());
        end
        rsp_pending = 1'b1;
        rsp_addr    = mem_req_addr;
        rsp_wait    = latency;
      end
      pix_ready = ($urandom_range(0, 99) < ready_pct);
    end
  end

  // Monitor: samples on the falling edge, pops and compares on each handshake
  int          beats_seen = 0, ones_seen = 0, eol_seen = 0, sof_seen = 0, eof_seen = 0;
  int          consumed = 0;
  int          buf_off  = 0;
  logic        expect_done = 1'b0;
  logic        stall_prev  = 1'b0;
  logic [15:0] stall_snap;

  initial begin
    logic [15:0] act;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_prev  = 1'b0;
        expect_done = 1'b0;
      end else begin
        act = {pix_data, pix_x, pix_y, pix_sof, pix_eol, pix_eof};
        if (expect_done) begin
          check("done_busy_valid_after_eof", {done, busy, pix_valid}, 3'b100);
          expect_done = 1'b0;
        end else if (done) begin
          check("spurious_done", done, 0);
        end
        if (stall_prev) check("stall_hold", {pix_valid, act}, {1'b1, stall_snap});
        stall_prev = pix_valid && !pix_ready;
        stall_snap = act;
        if (pix_valid && pix_ready) begin
          beats_seen++;
          ones_seen += int'(pix_data);
          eol_seen  += int'(pix_eol);
          sof_seen  += int'(pix_sof);
          eof_seen  += int'(pix_eof);
          if (exp_beats.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL beat_unexpected: got 0x%0h, expected no beat", act);
          end else begin
            check("beat", act, exp_beats.pop_front());
          end
          if (pix_eof) expect_done = 1'b1;
          if (pix_eol && pix_y[3:0] == 4'hF) begin
            check("lines_buffered_le2", (delivered - consumed - buf_off) <= 2, 1);
            consumed++;
          end
        end
      end
    end
  end

  // Main sequence
  int b0, o0, e0, s0, f0;

  task automatic run_frame(input logic [31:0] base_raw);
    cur_base = base_raw & ~32'h7F;
    for (int i = 0; i < 4; i++) exp_addrs.push_back(cur_base + 32'(128 * i));
    for (int p = 0; p < NPIX; p++) exp_beats.push_back(golden(p));
    b0 = beats_seen; o0 = ones_seen; e0 = eol_seen; s0 = sof_seen; f0 = eof_seen;
    start   = 1'b1;
    fb_base = base_raw;
    @(posedge clk); #1;
    start = 1'b0;
    check("req_one_cycle_after_start", {busy, mem_req_valid}, 2'b11);
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_checks++;
      n_errors++;
      $display("FAIL done_timeout: got no done, expected done within %0d cycles", budget);
    end
  endtask

  task automatic end_frame_checks();
    check("frame_beats", beats_seen - b0, NPIX);
    check("frame_eol_count", eol_seen - e0, H);
    check("frame_sof_count", sof_seen - s0, 1);
    check("frame_eof_count", eof_seen - f0, 1);
    check("beats_left", exp_beats.size(), 0);
    check("reqs_left", exp_addrs.size(), 0);
  endtask

  initial begin
    int dx, dy, r2;
    bit reached;
    rst_n   = 1'b0;
    start   = 1'b0;
    fb_base = '0;
    img     = '0;
    cur_base = 32'h2000;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctrl", {busy, done, mem_req_valid, pix_valid, pix_sof, pix_eol, pix_eof, pix_data}, 8'h00);
    check("rst_addr", mem_req_addr, 0);
    check("rst_xy", {pix_x, pix_y}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // single pixel at (5,3), 20-cycle memory latency, low base bits ignored
    img = '0;
    img[3*W + 5] = 1'b1;
    latency = 20; ready_pct = 100;
    run_frame(32'h2000 | 32'h5A);
    wait_done(20000);
    end_frame_checks();
    check("single_pixel_ones", ones_seen - o0, 1);
    repeat (3) @(posedge clk);
    #1;

    // random image, 30% ready, plus a start while busy
    for (int i = 0; i < NPIX / 32; i++) img[i*32 +: 32] = $urandom;
    latency = 3; ready_pct = 30;
    run_frame(32'h2000);
    repeat (200) @(posedge clk);
    #1;
    start = 1'b1; fb_base = 32'h9000;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(40000);
    end_frame_checks();
    repeat (2) @(posedge clk);
    #1;

    // torus image, then a back-to-back start on the done cycle
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        dx = x - 32; dy = y - 32; r2 = dx*dx + dy*dy;
        img[y*W + x] = (r2 >= 100) && (r2 <= 484);
      end
    latency = 5; ready_pct = 100;
    run_frame(32'h4000);
    wait_done(20000);
    end_frame_checks();
    for (int i = 0; i < NPIX / 32; i++) img[i*32 +: 32] = $urandom;
    run_frame(32'h4000);
    wait_done(20000);
    end_frame_checks();
    repeat (2) @(posedge clk);
    #1;

    // reset mid-frame with a line fetch in flight
    latency = 1500; ready_pct = 100;
    run_frame(32'h2000);
    reached = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      @(posedge clk); #1;
      if (beats_seen - b0 >= 2000) begin
        reached = 1'b1;
        break;
      end
    end
    if (!reached) begin
      n_checks++;
      n_errors++;
      $display("FAIL reach_p2000: got %0d beats, expected 2000", beats_seen - b0);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_ctrl", {busy, done, mem_req_valid, pix_valid, pix_sof, pix_eol, pix_eof, pix_data}, 8'h00);
    check("midrst_addr", mem_req_addr, 0);
    check("midrst_xy", {pix_x, pix_y}, 0);
    exp_beats.delete();
    exp_addrs.delete();
    buf_off = delivered - consumed;
    rst_n = 1'b1;
    reached = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (!rsp_pending) begin
        reached = 1'b1;
        break;
      end
    end
    check("late_rsp_delivered", reached, 1);
    repeat (3) @(posedge clk);
    #1;
    check("late_rsp_ignored", {busy, pix_valid, mem_req_valid}, 3'b000);
    latency = 4; ready_pct = 50;
    run_frame(32'h0001_0000);
    wait_done(30000);
    end_frame_checks();

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1, "watchdog");
  end

endmodule
